// File: rtl/ahb_fetch_unit.sv
// AHB-Lite instruction-fetch master: one NONSEQ word read per fetch, wait-state
// tolerant, valid/ready hand-off to decode and a one-cycle if_en back to the PC.
module ahb_fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                PC_STEP  = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'hA0000004,
    parameter int                TIMEOUT  = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_addr,
    input  logic              ex_en,
    output logic [ADDR_W-1:0] pc_next,
    output logic              if_en,
    output logic [ADDR_W-1:0] HADDR,
    output logic [1:0]        HTRANS,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic [2:0]        HBURST,
    input  logic              HREADY,
    input  logic              HRESP,
    input  logic [DATA_W-1:0] HRDATA,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic              fetch_err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, ERR} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] fetch_addr;
    logic [CW-1:0]     wait_cnt, wait_cnt_nxt;
    logic              start, capture, to_err;

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        start        = 1'b0;
        capture      = 1'b0;
        to_err       = 1'b0;
        case (state)
            IDLE: begin
                // if_en=0 gives the PC one cycle to settle before pc_addr is latched
                if (!ex_en && !if_en && (!instr_valid || instr_ready)) begin
                    start     = 1'b1;
                    state_nxt = ADDR;
                end
            end
            ADDR: begin
                if (HREADY) begin
                    state_nxt    = DATA;
                    wait_cnt_nxt = '0;
                end
            end
            DATA: begin
                if (HREADY) begin
                    if (HRESP) to_err  = 1'b1;
                    else       capture = 1'b1;
                end else if (HRESP) begin
                    to_err = 1'b1;
                end else begin
                    wait_cnt_nxt = wait_cnt + 1'b1;
                    if (wait_cnt_nxt == CW'(TIMEOUT)) to_err = 1'b1;
                end
                if (to_err)       state_nxt = ERR;
                else if (capture) state_nxt = IDLE;
            end
            ERR:     state_nxt = ERR;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            fetch_addr  <= '0;
            wait_cnt    <= '0;
            instr       <= '0;
            instr_valid <= 1'b0;
            if_en       <= 1'b0;
            fetch_err   <= 1'b0;
            pc_next     <= RESET_PC;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if_en    <= capture;
            if (start) fetch_addr <= pc_addr;
            if (capture) begin
                instr       <= HRDATA;
                instr_valid <= 1'b1;
                pc_next     <= fetch_addr + ADDR_W'(PC_STEP);
            end else if (instr_ready) begin
                instr_valid <= 1'b0;
            end
            if (to_err) fetch_err <= 1'b1;
        end
    end

    assign HTRANS = (state == ADDR) ? 2'b10 : 2'b00;
    assign HADDR  = fetch_addr;
    assign HWRITE = 1'b0;
    assign HSIZE  = 3'b010;
    assign HBURST = 3'b000;

endmodule

// File: tb/tb_ahb_fetch_unit.sv
// Directed bench for ahb_fetch_unit: cycle-by-cycle stimulus with hand-computed
// expectations for fetch timing, wait states, backpressure, ex_en, errors and reset.
module tb_ahb_fetch_unit;

    logic        clk;
    logic        reset;
    logic [31:0] pc_addr;
    logic        ex_en;
    logic [31:0] pc_next;
    logic        if_en;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic        HREADY;
    logic        HRESP;
    logic [31:0] HRDATA;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        fetch_err;

    int total;
    int passed;

    ahb_fetch_unit dut (
        .clk(clk), .reset(reset), .pc_addr(pc_addr), .ex_en(ex_en),
        .pc_next(pc_next), .if_en(if_en), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HREADY(HREADY),
        .HRESP(HRESP), .HRDATA(HRDATA), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .fetch_err(fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge; inputs set here apply to this cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold ex_en high long enough for any in-flight fetch to drain to IDLE.
    task automatic park();
        ex_en = 1'b1;
        HREADY = 1'b1;
        HRESP = 1'b0;
        instr_ready = 1'b1;
        repeat (4) tick();
    endtask

    task automatic test_reset();
        total++; if (HTRANS !== 2'b00) $display("FAIL rst_htrans: got %b exp 00", HTRANS); else passed++;
        total++; if (HADDR !== 32'h0) $display("FAIL rst_haddr: got %h exp 0", HADDR); else passed++;
        total++; if (instr !== 32'h0) $display("FAIL rst_instr: got %h exp 0", instr); else passed++;
        total++; if (instr_valid !== 1'b0) $display("FAIL rst_valid: got %b exp 0", instr_valid); else passed++;
        total++; if (if_en !== 1'b0) $display("FAIL rst_if_en: got %b exp 0", if_en); else passed++;
        total++; if (fetch_err !== 1'b0) $display("FAIL rst_err: got %b exp 0", fetch_err); else passed++;
        total++; if (pc_next !== 32'hA0000004) $display("FAIL rst_pc_next: got %h exp a0000004", pc_next); else passed++;
        total++; if ({HWRITE, HSIZE, HBURST} !== 7'b0_010_000)
            $display("FAIL rst_ctrl: got %b exp 0010000", {HWRITE, HSIZE, HBURST}); else passed++;
    endtask

    task automatic test_basic();
        pc_addr = 32'hA0000004; HRDATA = 32'h00A00093; ex_en = 1'b0; reset = 1'b0;   // cycle 0
        tick();                                                                        // cycle 1
        total++; if (HTRANS !== 2'b10) $display("FAIL basic_nonseq: got %b exp 10", HTRANS); else passed++;
        total++; if (HADDR !== 32'hA0000004) $display("FAIL basic_haddr: got %h exp a0000004", HADDR); else passed++;
        tick();                                                                        // cycle 2
        total++; if (HTRANS !== 2'b00) $display("FAIL basic_data_idle: got %b exp 00", HTRANS); else passed++;
        total++; if (instr_valid !== 1'b0) $display("FAIL basic_early_valid: got %b exp 0", instr_valid); else passed++;
        tick();                                                                        // cycle 3
        total++; if (instr !== 32'h00A00093) $display("FAIL basic_instr: got %h exp 00a00093", instr); else passed++;
        total++; if (instr_valid !== 1'b1) $display("FAIL basic_valid: got %b exp 1", instr_valid); else passed++;
        total++; if (if_en !== 1'b1) $display("FAIL basic_if_en: got %b exp 1", if_en); else passed++;
        total++; if (pc_next !== 32'hA0000008) $display("FAIL basic_pc_next: got %h exp a0000008", pc_next); else passed++;
        pc_addr = 32'hA0000008;
        tick();                                                                        // cycle 4
        total++; if (if_en !== 1'b0) $display("FAIL basic_if_pulse: got %b exp 0", if_en); else passed++;
        total++; if (HTRANS !== 2'b00) $display("FAIL basic_c4_idle: got %b exp 00", HTRANS); else passed++;
        tick();                                                                        // cycle 5
        total++; if (HTRANS !== 2'b10) $display("FAIL basic_next_nonseq: got %b exp 10", HTRANS); else passed++;
        total++; if (HADDR !== 32'hA0000008) $display("FAIL basic_next_haddr: got %h exp a0000008", HADDR); else passed++;
        park();
    endtask

    task automatic test_wait_states();
        pc_addr = 32'hA0000100; HRDATA = 32'hDEADBEEF; ex_en = 1'b0;                 // cycle 0
        tick();                                                                        // cycle 1
        total++; if (HTRANS !== 2'b10) $display("FAIL wait_nonseq: got %b exp 10", HTRANS); else passed++;
        tick();                                                                        // cycle 2
        HREADY = 1'b0;
        for (int i = 0; i < 3; i++) begin                                              // cycles 3..5
            tick();
            if (i == 2) HREADY = 1'b1;
            total++; if ({HTRANS, instr_valid, if_en} !== 4'b0000)
                $display("FAIL wait_hold%0d: got %b exp 0000", i, {HTRANS, instr_valid, if_en}); else passed++;
        end
        tick();                                                                        // cycle 6
        total++; if ({instr_valid, if_en} !== 2'b11) $display("FAIL wait_capture: got %b exp 11", {instr_valid, if_en}); else passed++;
        total++; if (instr !== 32'hDEADBEEF) $display("FAIL wait_instr: got %h exp deadbeef", instr); else passed++;
        total++; if (pc_next !== 32'hA0000104) $display("FAIL wait_pc_next: got %h exp a0000104", pc_next); else passed++;
        ex_en = 1'b1;
        tick();                                                                        // cycle 7
        total++; if (if_en !== 1'b0) $display("FAIL wait_if_pulse: got %b exp 0", if_en); else passed++;
        park();
    endtask

    task automatic test_backpressure();
        pc_addr = 32'hA0000200; HRDATA = 32'h11111111; instr_ready = 1'b0; ex_en = 1'b0;
        tick(); tick(); tick();                                                        // cycle 3
        total++; if ({instr_valid, if_en} !== 2'b11) $display("FAIL bp_capture: got %b exp 11", {instr_valid, if_en}); else passed++;
        pc_addr = 32'hA0000204; HRDATA = 32'h99999999;
        for (int i = 0; i < 6; i++) begin                                              // cycles 4..9
            tick();
            total++; if ({HTRANS, instr_valid} !== 3'b001 || instr !== 32'h11111111)
                $display("FAIL bp_hold%0d: got htrans=%b valid=%b instr=%h exp 00/1/11111111", i, HTRANS, instr_valid, instr); else passed++;
        end
        instr_ready = 1'b1;                                                            // cycle 9 decision
        tick();                                                                        // cycle 10
        total++; if (HTRANS !== 2'b10) $display("FAIL bp_nonseq: got %b exp 10", HTRANS); else passed++;
        total++; if (HADDR !== 32'hA0000204) $display("FAIL bp_haddr: got %h exp a0000204", HADDR); else passed++;
        total++; if (instr_valid !== 1'b0) $display("FAIL bp_consumed: got %b exp 0", instr_valid); else passed++;
        park();
    endtask

    task automatic test_ex_en();
        for (int i = 0; i < 4; i++) begin
            total++; if (HTRANS !== 2'b00) $display("FAIL exen_block%0d: got %b exp 00", i, HTRANS); else passed++;
            tick();
        end
        pc_addr = 32'hA0000300; HRDATA = 32'h22222222; ex_en = 1'b0;                 // cycle 0
        tick();                                                                        // cycle 1
        total++; if (HTRANS !== 2'b10) $display("FAIL exen_nonseq: got %b exp 10", HTRANS); else passed++;
        tick();                                                                        // cycle 2
        ex_en = 1'b1;
        tick();                                                                        // cycle 3
        total++; if (if_en !== 1'b1) $display("FAIL exen_complete: got %b exp 1", if_en); else passed++;
        total++; if (instr !== 32'h22222222) $display("FAIL exen_instr: got %h exp 22222222", instr); else passed++;
        tick(); tick();                                                                // cycle 5
        total++; if (HTRANS !== 2'b00) $display("FAIL exen_no_refetch: got %b exp 00", HTRANS); else passed++;
        park();
    endtask

    task automatic test_reset_mid();
        pc_addr = 32'hA0000500; ex_en = 1'b0;                                         // cycle 0
        tick();                                                                        // cycle 1
        HREADY = 1'b0;
        tick();                                                                        // cycle 2: still ADDR
        total++; if (HTRANS !== 2'b10) $display("FAIL rmid_stall: got %b exp 10", HTRANS); else passed++;
        reset = 1'b1;
        #1;
        total++; if (HTRANS !== 2'b00) $display("FAIL rmid_htrans: got %b exp 00", HTRANS); else passed++;
        total++; if (instr_valid !== 1'b0) $display("FAIL rmid_valid: got %b exp 0", instr_valid); else passed++;
        total++; if (pc_next !== 32'hA0000004) $display("FAIL rmid_pc_next: got %h exp a0000004", pc_next); else passed++;
        tick();
        HREADY = 1'b1; reset = 1'b0;                                                   // cycle 0 after release
        tick();
        total++; if (HTRANS !== 2'b10 || HADDR !== 32'hA0000500)
            $display("FAIL rmid_restart: got %b/%h exp 10/a0000500", HTRANS, HADDR); else passed++;
        park();
    endtask

    task automatic test_err_resp();
        pc_addr = 32'hA0000400; ex_en = 1'b0;
        tick(); tick();                                                                // cycle 2: data phase
        HREADY = 1'b0; HRESP = 1'b1;
        tick();
        HREADY = 1'b1;
        total++; if (fetch_err !== 1'b1) $display("FAIL err_flag: got %b exp 1", fetch_err); else passed++;
        for (int i = 0; i < 4; i++) begin
            tick();
            HRESP = 1'b0;
            total++; if ({HTRANS, if_en, fetch_err} !== 4'b0001)
                $display("FAIL err_terminal%0d: got %b exp 0001", i, {HTRANS, if_en, fetch_err}); else passed++;
        end
        reset = 1'b1; ex_en = 1'b1;
        tick(); tick();
        reset = 1'b0;
        total++; if (fetch_err !== 1'b0) $display("FAIL err_cleared: got %b exp 0", fetch_err); else passed++;
        park();
    endtask

    task automatic test_timeout();
        pc_addr = 32'hA0000600; ex_en = 1'b0;
        tick(); tick();                                                                // cycle 2: data phase
        HREADY = 1'b0;
        repeat (14) tick();
        total++; if (fetch_err !== 1'b0) $display("FAIL tmo_early: got %b exp 0", fetch_err); else passed++;
        tick();
        total++; if (fetch_err !== 1'b1) $display("FAIL tmo_flag: got %b exp 1", fetch_err); else passed++;
        HREADY = 1'b1;
        tick(); tick();
        total++; if ({HTRANS, if_en, instr_valid} !== 4'b0000)
            $display("FAIL tmo_terminal: got %b exp 0000", {HTRANS, if_en, instr_valid}); else passed++;
    endtask

    initial begin
        total = 0; passed = 0;
        reset = 1'b1; pc_addr = 32'hA0000004; ex_en = 1'b0;
        HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h0; instr_ready = 1'b1;
        tick(); tick();
        test_reset();
        test_basic();
        test_wait_states();
        test_backpressure();
        test_ex_en();
        test_reset_mid();
        test_err_resp();
        test_timeout();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
